// File: rtl/fwd_scoreboard.sv
// Operand-forwarding scoreboard for the in-order core: tracks in-flight destinations
// from EX onward, emits registered forward selects and the load-use stall.
// Optional stall-cycle counter is built when FWD_STALL_CNT_EN is defined.

module fwd_port_cmp #(
   parameter int NE         = 2,
   parameter int LOAD_STAGE = 2,
   parameter int ZERO_REG   = 31,
   parameter int SEL_W      = 2
) (
   input  logic [NE-1:0]       vld,
   input  logic [NE-1:0][4:0]  rd,
   input  logic [NE-1:0]       ld,
   input  logic [4:0]          rs,
   input  logic                used,
   output logic [SEL_W-1:0]    sel,
   output logic                ld_hz
);
   // Walk oldest to youngest so the youngest match is the one that sticks.
   always_comb begin
      sel   = '0;
      ld_hz = 1'b0;
      for (int j = NE-1; j >= 0; j--) begin
         if (vld[j] && used && (rd[j] == rs) && (rs != 5'(ZERO_REG))) begin
            sel   = SEL_W'(j + 1);
            ld_hz = ld[j] && ((j + 1) < LOAD_STAGE);
         end
      end
   end
endmodule

module fwd_scoreboard #(
   parameter int NUM_RD     = 2,
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 2,
   parameter int ZERO_REG   = 31,
   parameter int SEL_W      = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    id_valid,
   input  logic                    id_regwrite,
   input  logic                    id_load,
   input  logic [4:0]              id_rd,
   input  logic [NUM_RD*5-1:0]     id_rs,
   input  logic [NUM_RD-1:0]       id_rs_used,
   input  logic                    flush,
   output logic                    stall,
   output logic [NUM_RD*SEL_W-1:0] fwd_sel,
   output logic                    fwd_valid,
   output logic [15:0]             stall_cnt
);
   // The oldest stage is write-through in the register file and never matches,
   // so only the DEPTH-1 younger entries need to be held.
   localparam int NE = DEPTH - 1;

   logic [NE-1:0]                   vld_pipe;
   logic [NE-1:0]                   ld_pipe;
   logic [NE-1:0][4:0]              rd_pipe;
   logic [NUM_RD-1:0][SEL_W-1:0]    cand;
   logic [NUM_RD-1:0]               hz;
   logic                            issue;

   for (genvar k = 0; k < NUM_RD; k++) begin : g_port
      fwd_port_cmp #(
         .NE(NE), .LOAD_STAGE(LOAD_STAGE), .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)
      ) u_cmp (
         .vld   (vld_pipe),
         .rd    (rd_pipe),
         .ld    (ld_pipe),
         .rs    (id_rs[5*k +: 5]),
         .used  (id_rs_used[k]),
         .sel   (cand[k]),
         .ld_hz (hz[k])
      );
   end

   assign stall = id_valid & ~flush & (|hz);
   assign issue = id_valid & ~stall & ~flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe  <= '0;
         ld_pipe   <= '0;
         rd_pipe   <= '0;
         fwd_sel   <= '0;
         fwd_valid <= 1'b0;
      end else begin
         vld_pipe[0] <= issue & id_regwrite & (id_rd != 5'(ZERO_REG));
         ld_pipe[0]  <= issue & id_load;
         rd_pipe[0]  <= id_rd;
         // A flush kills the EX entry before it can advance.
         for (int i = 1; i < NE; i++) begin
            if (i == 1) vld_pipe[i] <= vld_pipe[0] & ~flush;
            else        vld_pipe[i] <= vld_pipe[i-1];
            ld_pipe[i] <= ld_pipe[i-1];
            rd_pipe[i] <= rd_pipe[i-1];
         end
         fwd_sel   <= issue ? cand : '0;
         fwd_valid <= issue;
      end
   end

`ifdef FWD_STALL_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cnt <= '0;
      else if (stall && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end
`else
   assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard at default parameters; expected forward
// selects are queued when an ID instruction is driven and checked in its EX cycle.

module tb_fwd_scoreboard;
   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid, id_regwrite, id_load, flush;
   logic [4:0]  id_rd;
   logic [9:0]  id_rs;
   logic [1:0]  id_rs_used;
   logic        stall;
   logic [3:0]  fwd_sel;
   logic        fwd_valid;
   logic [15:0] stall_cnt;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;
   logic [4:0] exp_q[$];

`ifdef FWD_STALL_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   fwd_scoreboard dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_regwrite(id_regwrite),
      .id_load(id_load), .id_rd(id_rd), .id_rs(id_rs), .id_rs_used(id_rs_used),
      .flush(flush), .stall(stall), .fwd_sel(fwd_sel), .fwd_valid(fwd_valid),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_cnt(input string tag);
      chk(tag, {16'h0, stall_cnt}, CNT_EN ? exp_cnt : 0);
   endtask

   // Drive one ID cycle, check stall, queue the EX-cycle expectation, then
   // check it one edge later.
   task automatic cyc(input logic v, input logic rw, input logic ld, input logic [4:0] rd,
                      input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] used,
                      input logic fl, input logic es, input logic [1:0] e0,
                      input logic [1:0] e1, input logic efv, input string tag);
      logic [4:0] e;
      id_valid = v; id_regwrite = rw; id_load = ld; id_rd = rd;
      id_rs = {r1, r0}; id_rs_used = used; flush = fl;
      #1;
      chk({tag, " stall"}, {31'h0, stall}, {31'h0, es});
      exp_q.push_back({efv, e1, e0});
      if (es) exp_cnt++;
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s queue: got empty expected entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, " fwd_sel"}, {28'h0, fwd_sel}, {28'h0, e[3:0]});
         chk({tag, " fwd_valid"}, {31'h0, fwd_valid}, {31'h0, e[4]});
      end
   endtask

   task automatic drain();
      cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, "idle");
      cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, "idle");
   endtask

   initial begin
      reset = 1'b1; id_valid = 0; id_regwrite = 0; id_load = 0; id_rd = 0;
      id_rs = 0; id_rs_used = 0; flush = 0;
      #2;
      chk("reset stall", {31'h0, stall}, 0);
      chk("reset fwd_sel", {28'h0, fwd_sel}, 0);
      chk("reset fwd_valid", {31'h0, fwd_valid}, 0);
      chk_cnt("reset stall_cnt");
      @(posedge clk); #1 reset = 1'b0;

      // ALU to ALU
      cyc(1, 1, 0, 1, 2, 3, 2'b11, 0, 0, 0, 0, 1, "alu add x1");
      cyc(1, 1, 0, 2, 1, 3, 2'b11, 0, 0, 1, 0, 1, "alu add x2");
      drain();

      // two apart, then three apart
      cyc(1, 1, 0, 1, 2, 3, 2'b11, 0, 0, 0, 0, 1, "two add x1");
      cyc(1, 1, 0, 9, 10, 11, 2'b11, 0, 0, 0, 0, 1, "two gap");
      cyc(1, 1, 0, 4, 1, 1, 2'b11, 0, 0, 2, 2, 1, "two sub x4");
      drain();
      cyc(1, 1, 0, 1, 2, 3, 2'b11, 0, 0, 0, 0, 1, "three add x1");
      cyc(1, 1, 0, 9, 10, 11, 2'b11, 0, 0, 0, 0, 1, "three gap a");
      cyc(1, 1, 0, 8, 12, 13, 2'b11, 0, 0, 0, 0, 1, "three gap b");
      cyc(1, 1, 0, 4, 1, 1, 2'b11, 0, 0, 0, 0, 1, "three sub x4");
      drain();

      // load-use
      cyc(1, 1, 1, 5, 2, 0, 2'b01, 0, 0, 0, 0, 1, "lu ldur x5");
      cyc(1, 1, 0, 6, 5, 7, 2'b11, 0, 1, 0, 0, 0, "lu stall");
      cyc(1, 1, 0, 6, 5, 7, 2'b11, 0, 0, 2, 0, 1, "lu issue");
      chk_cnt("lu stall_cnt");
      drain();

      // priority: youngest writer wins
      cyc(1, 1, 0, 1, 2, 3, 2'b11, 0, 0, 0, 0, 1, "prio add x1 a");
      cyc(1, 1, 0, 1, 2, 3, 2'b11, 0, 0, 0, 0, 1, "prio add x1 b");
      cyc(1, 1, 0, 3, 1, 20, 2'b11, 0, 0, 1, 0, 1, "prio reader");
      drain();

      // zero register: loading X31 then reading it
      cyc(1, 1, 1, 31, 2, 3, 2'b11, 0, 0, 0, 0, 1, "zr ldur x31");
      cyc(1, 1, 0, 4, 31, 31, 2'b11, 0, 0, 0, 0, 1, "zr reader");
      drain();

      // unused source port
      cyc(1, 1, 0, 1, 2, 3, 2'b11, 0, 0, 0, 0, 1, "unused add x1");
      cyc(1, 1, 0, 4, 3, 1, 2'b01, 0, 0, 0, 0, 1, "unused reader");
      cyc(1, 1, 1, 7, 2, 3, 2'b11, 0, 0, 0, 0, 1, "unused ldur x7");
      cyc(1, 1, 0, 8, 7, 7, 2'b00, 0, 0, 0, 0, 1, "unused ld reader");
      drain();

      // flush kills the load in EX
      cyc(1, 1, 1, 5, 2, 0, 2'b01, 0, 0, 0, 0, 1, "fl ldur x5");
      cyc(1, 1, 0, 6, 5, 7, 2'b11, 1, 0, 0, 0, 0, "fl flush");
      cyc(1, 1, 0, 9, 5, 5, 2'b11, 0, 0, 0, 0, 1, "fl reader");
      chk_cnt("fl stall_cnt");
      drain();

      // reset while stalled
      cyc(1, 1, 1, 5, 2, 0, 2'b01, 0, 0, 0, 0, 1, "rst ldur x5");
      id_valid = 1; id_regwrite = 1; id_load = 0; id_rd = 6;
      id_rs = {5'd7, 5'd5}; id_rs_used = 2'b11; flush = 0;
      #1;
      chk("rst pre stall", {31'h0, stall}, 1);
      #1 reset = 1'b1;
      #1;
      exp_cnt = 0;
      chk("rst stall", {31'h0, stall}, 0);
      chk("rst fwd_sel", {28'h0, fwd_sel}, 0);
      chk("rst fwd_valid", {31'h0, fwd_valid}, 0);
      chk_cnt("rst stall_cnt");
      id_valid = 0;
      @(posedge clk); #1 reset = 1'b0;
      cyc(1, 1, 0, 9, 5, 5, 2'b11, 0, 0, 0, 0, 1, "post rst reader");
      chk_cnt("post rst stall_cnt");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the pipeline forwarding logic for the LEGv8-style in-order core.
- Keeps an internal shift-register scoreboard of in-flight destination registers, one entry per stage from EX onward.
- Compares the ID-stage instruction's NUM_RD source operands against the scoreboard and produces registered per-operand forward selects for the following EX cycle.
- Generates the load-use stall and inserts bubbles into the scoreboard.

Parameters:
- NUM_RD, 2, number of source-operand ports checked per instruction.
- DEPTH, 3, tracked stages from EX onward (EX, MEM, WB); legal range 2..8.
- LOAD_STAGE, 2, lowest forward select at which load data exists; legal range 1..DEPTH-1.
- ZERO_REG, 31, architectural zero register; never forwarded, never causes a stall.
- SEL_W, $clog2(DEPTH), width of each forward select (derived, not overridden).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_regwrite  in  1  ID instruction writes id_rd
- id_load  in  1  ID instruction is a load (LDUR)
- id_rd  in  5  ID destination register
- id_rs  in  NUM_RD*5  ID source registers, port k at [5k+4:5k]
- id_rs_used  in  NUM_RD  port k is actually read (e.g. 0 for Rm when ALUSrc=1)
- flush  in  1  kill the ID instruction and the EX-stage entry
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- fwd_sel  out  NUM_RD*SEL_W  registered per-port select for the instruction now in EX; 0 = register file, j = result held j pipeline registers past EX
- fwd_valid  out  1  registered: the EX instruction was genuinely issued
- stall_cnt  out  16  saturating stall-cycle count; present only with the optional feature

Behaviour:
- Entry fields: valid, rd, load. Entry 0 = EX. All entries shift 0→1→…→DEPTH-1 every cycle. Entry DEPTH-1 retires after that cycle.
- Issue condition: issue = id_valid & !stall & !flush.
- Entry 0 next value:
  - If issue: {id_regwrite & (id_rd != ZERO_REG), id_rd, id_load}.
  - Otherwise: a bubble (valid=0).
- Match, port k at entry j:
  - j ≤ DEPTH-2, entry j valid, entry rd == id_rs[k], id_rs_used[k]=1, id_rs[k] != ZERO_REG.
  - Entry DEPTH-1 never matches; the register file is write-through.
- Priority: the lowest j (youngest) wins. Port k's candidate select is j+1, or 0 when there is no match.
- stall = id_valid & !flush & (for any k, the winning entry is a load with j+1 < LOAD_STAGE). Only the winning entry is tested; older entries are never tested.
- fwd_sel register:
  - On issue, loads the candidate selects.
  - Otherwise loads all zeros.
  - fwd_valid <= issue.
- Latency: select computed in ID cycle N, visible at fwd_sel in EX cycle N+1.
- Flush:
  - Entry 0 next becomes a bubble.
  - The current entry 0 is invalidated before the shift, so it does not advance into entry 1.
  - Entries 1..DEPTH-1 shift normally.
  - stall is forced to 0; fwd_sel and fwd_valid load 0.
- Stall: bubble enters entry 0 and older entries keep shifting, so the load-use stall resolves on its own after LOAD_STAGE-1 cycles.
- Simultaneous flush and stall condition: flush wins; stall=0.
- id_valid=0: no stall, bubble issued, selects 0.
- Reset (asynchronous, any time, including mid-stall): all entries invalid, fwd_sel=0, fwd_valid=0, stall_cnt=0. stall goes low immediately, because no entries are valid.

Optional Feature:
- Macro FWD_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on each clk edge where stall=1.
  - It saturates at 16'hFFFF.
  - It is cleared only by reset.
- Undefined:
  - The counter is not built and stall_cnt is driven 16'h0000.
  - All other behaviour is identical.

Test Plan:
- ALU-to-ALU, default parameters: issue ADD X1, then ADD X2,X1,X3 next cycle -> no stall; the second instruction's EX cycle shows fwd_sel port0=1, port1=0, fwd_valid=1.
- Two-apart: ADD X1; unrelated instruction; SUB X4,X1,X1 -> both ports select 2 in SUB's EX cycle. At three apart, both ports select 0.
- Load-use: LDUR X5; ADD X6,X5,X7 -> stall=1 for exactly one cycle and entry 0 is a bubble. ADD then issues with port0 select=2. With FWD_STALL_CNT_EN defined, stall_cnt=1.
- Priority and zero register:
  - ADD X1; ADD X1; reader of X1 -> select 1, not 2.
  - Writer of X31 followed by reader of X31 -> select 0, no stall.
  - id_rs_used=0 on a matching port -> select 0.
- Flush: LDUR X5, then flush asserted together with a dependent ADD X6,X5 in ID -> stall=0, fwd_valid=0 next cycle. A following reader of X5 sees no match, because the load entry was killed.
- Reset mid-stall: assert reset while stall=1 -> stall drops asynchronously. fwd_sel=0, fwd_valid=0, stall_cnt=0. First post-reset instruction sees no matches.
